// File: rtl/regfile_rsp.sv
// 32x32 register file behind a valid/ready request/response handshake.
// Reads are write-first and registered; one request per cycle when the response is consumed.
module regfile_rsp (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        RegWrite,
  input  logic [4:0]  WriteRegister,
  input  logic [31:0] WriteData,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic        ZeroWriteErr,
  output logic [15:0] ReqCount
);

  logic [31:0] regs [32];
  logic        accept;
  logic        wr_en;
  logic        zero_wr;
  logic [31:0] rd1_next;
  logic [31:0] rd2_next;

  // Ready depends only on the response slot, never on ReqValid.
  assign ReqReady = !RspValid || RspReady;
  assign accept   = ReqValid && ReqReady;
  assign wr_en    = accept && RegWrite && (WriteRegister != 5'd0);
  assign zero_wr  = accept && RegWrite && (WriteRegister == 5'd0);

  // Register 0 is never written, so it reads 0 without a special case.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rd1_next = regs[ReadRegister1];
    rd2_next = regs[ReadRegister2];
    if (wr_en && (WriteRegister == ReadRegister1)) rd1_next = WriteData;
    if (wr_en && (WriteRegister == ReadRegister2)) rd2_next = WriteData;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      // NOTE: the storage array is reset here because the block must come up all-zero;
      // a plain RAM without this loop would otherwise be the cheaper choice.
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      // NOTE: sequential state uses non-blocking assignments only.
      regs[WriteRegister] <= WriteData;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      RspValid  <= 1'b0;
      ReadData1 <= '0;
      ReadData2 <= '0;
    end else if (accept) begin
      RspValid  <= 1'b1;
      ReadData1 <= rd1_next;
      ReadData2 <= rd2_next;
    end else if (RspReady) begin
      RspValid  <= 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ReqCount     <= '0;
      ZeroWriteErr <= 1'b0;
    end else begin
      if (accept)  ReqCount     <= ReqCount + 16'd1;
      if (zero_wr) ZeroWriteErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_rsp.sv
// Scoreboard bench for regfile_rsp: directed scenarios, random traffic and a counter wrap,
// checked against an array/queue reference model.
module tb_regfile_rsp;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        ZeroWriteErr;
  logic [15:0] ReqCount;

  regfile_rsp dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .RspValid(RspValid), .RspReady(RspReady), .ReadData1(ReadData1),
    .ReadData2(ReadData2), .ZeroWriteErr(ZeroWriteErr), .ReqCount(ReqCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] m_mem [32];
  bit          m_valid;
  logic [15:0] m_count;
  bit          m_zerr;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    exp_q.delete();
    m_valid = 0;
    m_count = '0;
    m_zerr  = 0;
  endtask

  // Called at posedge+1; drives one cycle of inputs and updates the model after the edge.
  task automatic step(input bit v, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2, input bit rr);
    bit   acc;
    rsp_t e;
    ReqValid = v; RegWrite = we; WriteRegister = wa; WriteData = wd;
    ReadRegister1 = r1; ReadRegister2 = r2; RspReady = rr;
    acc  = v && (!m_valid || rr);
    e.d1 = (r1 == 0) ? 32'd0 : (we && wa == r1) ? wd : m_mem[r1];
    e.d2 = (r2 == 0) ? 32'd0 : (we && wa == r2) ? wd : m_mem[r2];
    @(posedge Clk);
    if (acc) begin
      if (we) begin
        if (wa == 0) m_zerr = 1;
        else         m_mem[wa] = wd;
      end
      m_count = m_count + 16'd1;
      exp_q.push_back(e);
      m_valid = 1;
    end else if (rr) begin
      m_valid = 0;
    end
    #1;
  endtask

  // Asserts Reset mid-cycle with a write request pending that must be ignored.
  task automatic do_reset();
    ReqValid = 1; RegWrite = 1; WriteRegister = 5'd3; WriteData = 32'hDEAD_BEEF;
    ReadRegister1 = 5'd3; ReadRegister2 = 5'd3; RspReady = 1;
    #1;
    Reset = 1;
    model_clear();
    #1;
    check("rst_rsp_valid", RspValid, 0);
    check("rst_rd1", ReadData1, 0);
    check("rst_rd2", ReadData2, 0);
    check("rst_count", ReqCount, 0);
    check("rst_zerr", ZeroWriteErr, 0);
    check("rst_req_ready", ReqReady, 1);
    @(posedge Clk);
    #1;
    check("rst_no_accept_count", ReqCount, 0);
    check("rst_no_accept_valid", RspValid, 0);
    Reset = 0;
  endtask

  // Monitor: checks handshake state every cycle and pops the scoreboard on each consumed response.
  always @(negedge Clk) begin
    rsp_t e;
    check("req_ready", ReqReady, (!m_valid || RspReady) ? 1 : 0);
    check("rsp_valid", RspValid, m_valid ? 1 : 0);
    check("req_count", ReqCount, m_count);
    check("zero_write_err", ZeroWriteErr, m_zerr ? 1 : 0);
    if (RspValid && RspReady) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: response presented with empty scoreboard at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_rd1", ReadData1, e.d1);
        check("sb_rd2", ReadData2, e.d2);
      end
    end
  end

  initial begin
    ReqValid = 0; RegWrite = 0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0; RspReady = 0;
    Reset = 0;
    model_clear();
    #1 Reset = 1;
    @(posedge Clk);
    #1;
    check("init_rsp_valid", RspValid, 0);
    check("init_count", ReqCount, 0);
    check("init_req_ready", ReqReady, 1);
    Reset = 0;

    // Write 42 to r2 with both reads of r2: accepted on the first edge after reset.
    step(1, 1, 5'd2, 32'd42, 5'd2, 5'd2, 1);
    check("wr42_valid", RspValid, 1);
    check("wr42_rd1", ReadData1, 32'd42);
    check("wr42_rd2", ReadData2, 32'd42);
    check("wr42_count", ReqCount, 16'd1);

    // Read-only request must not write its data.
    step(1, 1, 5'd2, 32'd15, 5'd2, 5'd2, 1);
    check("wr15_rd1", ReadData1, 32'd15);
    step(1, 0, 5'd2, 32'd20, 5'd2, 5'd2, 1);
    check("nowr_rd1", ReadData1, 32'd15);
    check("nowr_rd2", ReadData2, 32'd15);

    // Register 0 write is discarded and flagged.
    step(1, 1, 5'd0, 32'd15, 5'd0, 5'd0, 1);
    check("r0_rd1", ReadData1, 32'd0);
    check("r0_rd2", ReadData2, 32'd0);
    check("r0_zerr", ZeroWriteErr, 1);

    // Backpressure: 3 cycles with RspReady low, writes to r8 must be ignored.
    step(1, 0, 5'd0, 32'd0, 5'd2, 5'd2, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 5'd8, 32'd555, 5'd8, 5'd8, 0);
      check("hold_req_ready", ReqReady, 0);
      check("hold_valid", RspValid, 1);
      check("hold_rd1", ReadData1, 32'd15);
      check("hold_rd2", ReadData2, 32'd15);
      check("hold_count", ReqCount, 16'd5);
    end
    step(1, 1, 5'd7, 32'd99, 5'd8, 5'd7, 1);
    check("release_count", ReqCount, 16'd6);
    check("release_rd1_r8", ReadData1, 32'd0);
    check("release_rd2_r7", ReadData2, 32'd99);

    // Drain: valid drops, data keeps last values.
    step(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 1);
    check("drain_valid", RspValid, 0);
    check("drain_rd2", ReadData2, 32'd99);

    // Reset mid-cycle after writing r5, then r5 and r3 must read back 0.
    step(1, 1, 5'd5, 32'd7, 5'd5, 5'd5, 1);
    check("r5_rd1", ReadData1, 32'd7);
    do_reset();
    step(1, 0, 5'd0, 32'd0, 5'd5, 5'd3, 1);
    check("post_rst_rd1", ReadData1, 32'd0);
    check("post_rst_rd2", ReadData2, 32'd0);
    check("post_rst_count", ReqCount, 16'd1);

    // Random traffic over a small address range to exercise write-first and backpressure.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 7);
    end

    // Counter wrap: 65536 back-to-back accepts from a fresh reset.
    do_reset();
    for (int i = 0; i < 65536; i++) begin
      step(1, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1);
    end
    check("wrap_count", ReqCount, 16'd0);
    check("wrap_valid", RspValid, 1);

    step(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 1);
    @(posedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_rsp.md
REGFILE_RSP -- requirements
Module: regfile_rsp

Interface
REQ-001 SHALL have port Clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port ReqValid, input, 1 bit: initiator presents a request.
REQ-004 SHALL have port ReqReady, output, 1 bit: block can accept a request this cycle.
REQ-005 SHALL have port RegWrite, input, 1 bit: the request includes a write.
REQ-006 SHALL have port WriteRegister, input, 5 bits: write address.
REQ-007 SHALL have port WriteData, input, 32 bits: write data.
REQ-008 SHALL have port ReadRegister1, input, 5 bits: port-1 read address.
REQ-009 SHALL have port ReadRegister2, input, 5 bits: port-2 read address.
REQ-010 SHALL have port RspValid, output, 1 bit: response data is valid.
REQ-011 SHALL have port RspReady, input, 1 bit: initiator consumes the response.
REQ-012 SHALL have port ReadData1, output, 32 bits: port-1 read result.
REQ-013 SHALL have port ReadData2, output, 32 bits: port-2 read result.
REQ-014 SHALL have port ZeroWriteErr, output, 1 bit: sticky flag, set by any accepted write to register 0.
REQ-015 SHALL have port ReqCount, output, 16 bits: count of accepted requests.

Function
REQ-016 SHALL hold 32 registers of 32 bits each; register 0 SHALL always read 0.
REQ-017 SHALL accept a request on a rising edge where ReqValid=1 and ReqReady=1.
REQ-018 SHALL drive ReqReady = !RspValid | RspReady, combinationally; no combinational path from ReqValid to ReqReady.
REQ-019 On accept with RegWrite=1 and WriteRegister!=0, SHALL write WriteData to WriteRegister at that edge.
REQ-020 On accept with RegWrite=1 and WriteRegister=0, SHALL discard the data and set ZeroWriteErr to 1.
REQ-021 On accept, SHALL register the port-1 and port-2 read results into ReadData1/ReadData2 and set RspValid=1 at the same edge (1-cycle latency).
REQ-022 Reads SHALL be write-first: a read of the address written by the same request SHALL return the new WriteData (0 if the address is 0).
REQ-023 While RspValid=1 and RspReady=0, SHALL hold ReadData1, ReadData2 and RspValid stable and accept nothing.
REQ-024 On an edge with RspValid=1, RspReady=1 and no new accept, SHALL clear RspValid; ReadData1/2 SHALL keep their last values.
REQ-025 On an edge with RspReady=1 and a new accept, SHALL load the new response with RspValid staying 1 (back-to-back, one request per cycle).
REQ-026 RegWrite=1 with ReqValid=0 or ReqReady=0 SHALL NOT modify any register.
REQ-027 ReqCount SHALL increment by 1 per accept and wrap from 16'hFFFF to 0.
REQ-028 ZeroWriteErr SHALL remain set until Reset.

Reset
REQ-029 Reset=1 SHALL, asynchronously, clear all 32 registers, ReadData1, ReadData2, RspValid, ZeroWriteErr and ReqCount to 0.
REQ-030 While Reset=1, ReqReady SHALL be 1 and no request SHALL be accepted; a response pending when Reset is asserted SHALL be dropped.
REQ-031 The first accept SHALL occur on the first rising edge after Reset deasserts with ReqValid=1.

Verification
REQ-032 Write 42 to register 2, read ports 1 and 2 = 2, RspReady=1 -> next cycle RspValid=1, ReadData1=ReadData2=42.
REQ-033 Write 15 to register 2, then a RegWrite=0 request with WriteData=20 and reads of register 2 -> both responses give 15.
REQ-034 Write 15 to register 0 with reads of register 0 -> ReadData1=ReadData2=0, ZeroWriteErr=1.
REQ-035 Hold RspReady=0 for 3 cycles while ReqValid=1 -> ReqReady=0, response data stable, ReqCount unchanged; raise RspReady -> next request accepted on that edge.
REQ-036 Write 7 to register 5, assert Reset mid-cycle, then read register 5 -> RspValid drops at once, ReadData1=0, ReqCount=0.
REQ-037 Accept 65536 requests back-to-back with RspReady=1 -> ReqCount wraps to 0 and RspValid stays 1 throughout.
